conv_act_feeder: RTL
====================

// Module: conv_act_feeder
// PURPOSE
//  Streams an n x n activation map from a 1-cycle-latency read port into the
//  convolver's activation/ce input, in raster order. Issues one pixel per ce.
//  Appends DRAIN zero pixels with ce=1 so the MAC pipeline flushes.
//  Run control is start/busy/done, with downstream stall back-pressure.
// PARAMETERS
//  n      9'h00a  activation map size; n*n pixels are streamed
//  N      16      activation/pixel bit width
//  AW     16      memory address width; n*n <= 2**AW
//  DRAIN  2       zero pixels appended after the last real pixel
// PORTS
//  clk         in   1   clock; all state on posedge
//  global_rst  in   1   asynchronous active-high reset
//  start       in   1   1-cycle run request; sampled only in IDLE
//  base_addr   in   AW  map base address; latched when start is accepted
//  stall       in   1   downstream hold; while 1, ce=0 and no new read
//  mem_rd      out  1   read strobe; mem_data is valid exactly 1 cycle later
//  mem_addr    out  AW  read address = base_addr + pixel index
//  mem_data    in   N   read data
//  activation  out  N   pixel to the convolver; registered
//  ce          out  1   activation valid / convolver advance; registered
//  busy        out  1   high from start acceptance until done
//  done        out  1   1-cycle pulse after the last drain pixel is emitted
// BEHAVIOUR
//  Reset (async): state=IDLE; mem_rd=0, mem_addr=0, activation=0, ce=0,
//   busy=0, done=0; counters and skid are cleared.
//  FSM IDLE -> READ -> DRAIN -> FIN -> IDLE.
//   IDLE: on start, latch base_addr, set rd_idx=0 and out_cnt=0, and go to READ.
//    busy rises on the same edge. start in any other state is ignored.
//   READ: each cycle with stall=0 and rd_idx<n*n, drive mem_rd=1 and
//    mem_addr=base+rd_idx, then rd_idx++. When the read for index n*n-1 is
//    issued, go to DRAIN.
//   DRAIN: wait until all n*n real pixels are emitted. Then emit DRAIN pixels
//    of 0 with ce=1, one per cycle with stall=0, then go to FIN.
//   FIN: done=1 for one cycle, busy=0, go to IDLE.
//  Latency: with no stall, read issued in cycle t -> activation=mem_data with
//   ce=1 in cycle t+2. First ce comes 2 cycles after the first mem_rd.
//   The stream is gapless: n*n+DRAIN consecutive ce cycles.
//  ce is 1 only in cycles carrying a new pixel. When ce=0, activation holds
//   its last value.
//  Stall:
//   - In a cycle where stall=1: ce=0, mem_rd=0, activation holds.
//   - A read already in flight returns into a 1-entry skid register; no pixel
//    is dropped or duplicated.
//   - In the first cycle after stall falls, emit the skid pixel (if any)
//    before the next memory data. Reads resume so the stream stays in order.
//   - Stall during DRAIN pauses the zero pixels the same way.
//  mem_addr wraps modulo 2**AW when base+idx overflows; no error is flagged.
//  done and a new start can't coincide: start is only sampled in IDLE, the
//   cycle after FIN.
//  Async reset mid-run aborts immediately, with outputs at reset values.
//   There is no done pulse for the aborted run.
//  Invariant: total ce pulses per run = n*n + DRAIN, in strict raster order.
// TESTING
//  1 n=4,DRAIN=2, mem[i]=i+1, base=0, stall=0: start -> mem_rd at t..t+15;
//    ce=1 at t+2..t+19; activation 1..16 then 0,0; done at t+20.
//  2 Same, stall=1 for 3 cycles starting at the cycle the 5th pixel is emitted:
//    activation sequence is still 1..16,0,0 with no gap or repeat;
//    ce count is 18; done is 3 cycles later than in test 1.
//  3 base_addr=16'hFFFE, n=4: mem_addr = FFFE, FFFF, 0000..000D (wrap);
//    16 reads total.
//  4 start pulsed again while busy=1: ignored, and exactly 18 ce pulses occur.
//    A start in the cycle after done launches a second run.
//  5 global_rst asserted asynchronously mid-READ (between edges): ce, mem_rd
//    and busy go low at once, and no done pulse occurs.
//    A following start restarts from address base+0.
//  6 Toggle stall on alternate cycles for the whole run: 18 ce pulses,
//    values in order, and ce=0 in every cycle where stall=1.

Source files
------------

// File: rtl/conv_act_feeder.sv
// conv_act_feeder: streams an n x n activation map from a 1-cycle-latency
// read port into the convolver in raster order, then appends DRAIN zero
// pixels so the MAC pipeline flushes. start/busy/done run control, with a
// same-cycle stall that holds ce and mem_rd low; a single skid entry catches
// the read that is already in flight when a stall begins.
module conv_act_feeder #(
  parameter logic [8:0] n     = 9'h00a,
  parameter int         N     = 16,
  parameter int         AW    = 16,
  parameter int         DRAIN = 2
) (
  input  logic          clk,
  input  logic          global_rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic          stall,
  output logic          mem_rd,
  output logic [AW-1:0] mem_addr,
  input  logic [N-1:0]  mem_data,
  output logic [N-1:0]  activation,
  output logic          ce,
  output logic          busy,
  output logic          done
);

  localparam int NPIX = int'(n) * int'(n);
  localparam int IW   = $clog2(NPIX + 1);
  localparam int DW   = (DRAIN > 0) ? $clog2(DRAIN + 1) : 1;

  localparam logic [IW-1:0] LAST_IDX  = IW'(NPIX - 1);
  localparam logic [DW-1:0] DRAIN_CNT = DW'(DRAIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_DRAIN,
    S_FIN
  } state_t;

  state_t state;
  state_t state_next;

  // Run context
  logic [AW-1:0] base_q;
  logic [IW-1:0] rd_idx;
  logic [DW-1:0] drain_cnt;

  // Pipeline: read in flight, skid entry, output register
  logic          rd_vld;
  logic          skid_vld;
  logic [N-1:0]  skid_data;
  logic          out_vld;
  logic [N-1:0]  act_q;

  // Per-cycle decisions
  logic          accept;
  logic          issue;
  logic          inject;
  logic          consume;
  logic          out_free;
  logic          drain_done;

  // The output register is handed to the convolver whenever it holds a pixel
  // and the consumer is not stalling in this very cycle.
  assign consume  = out_vld && !stall;
  assign out_free = !out_vld || consume;

  // All real pixels are out of the read path and every zero pixel has been
  // queued; the output register is about to be empty.
  assign drain_done = (drain_cnt == DRAIN_CNT) && !skid_vld && !rd_vld && out_free;

  assign ce         = consume;
  assign mem_rd     = issue;
  assign mem_addr   = base_q + AW'(rd_idx);
  assign activation = act_q;

  // FSM state register
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic, read issue, zero injection and run-status outputs
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    issue      = 1'b0;
    inject     = 1'b0;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          accept     = 1'b1;
          state_next = S_READ;
        end
      end
      S_READ: begin
        busy = 1'b1;
        // A read whose data could find both the skid and the output register
        // occupied is held back; in practice only a stall can cause that.
        issue = !stall && !(skid_vld && rd_vld);
        if (issue && (rd_idx == LAST_IDX)) begin
          state_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        busy = 1'b1;
        // Zeros enter only behind the last real pixel, one per free slot.
        inject = (drain_cnt != DRAIN_CNT) && !skid_vld && !rd_vld && out_free;
        if (drain_done) begin
          state_next = S_FIN;
        end
      end
      S_FIN: begin
        done       = 1'b1;
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // Run context: base address latch, read index and drain counter
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      base_q    <= '0;
      rd_idx    <= '0;
      drain_cnt <= '0;
    end else if (accept) begin
      base_q    <= base_addr;
      rd_idx    <= '0;
      drain_cnt <= '0;
    end else begin
      if (issue) begin
        rd_idx <= rd_idx + IW'(1);
      end
      if (inject) begin
        drain_cnt <= drain_cnt + DW'(1);
      end
    end
  end

  // Marks the cycle in which mem_data carries the previous cycle's read
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      rd_vld <= 1'b0;
    end else begin
      rd_vld <= issue;
    end
  end

  // Output register and skid: oldest item (skid, then returning data, then an
  // injected zero) fills the output slot; returning data that cannot get the
  // output slot parks in the skid.
  always_ff @(posedge clk or posedge global_rst) begin
    if (global_rst) begin
      out_vld   <= 1'b0;
      act_q     <= '0;
      skid_vld  <= 1'b0;
      skid_data <= '0;
    end else if (out_free) begin
      if (skid_vld) begin
        act_q   <= skid_data;
        out_vld <= 1'b1;
        if (rd_vld) begin
          skid_data <= mem_data;
        end else begin
          skid_vld <= 1'b0;
        end
      end else if (rd_vld) begin
        act_q   <= mem_data;
        out_vld <= 1'b1;
      end else if (inject) begin
        act_q   <= '0;
        out_vld <= 1'b1;
      end else begin
        out_vld <= 1'b0;
      end
    end else if (rd_vld) begin
      skid_data <= mem_data;
      skid_vld  <= 1'b1;
    end
  end

endmodule
